// File: rtl/dsp_file_bank.sv
// Multi-file word store for the DSP equation engines: per-file read/write
// pointers, engine command handshake with re-arm guard, and a host append port.
module dsp_file_bank #(
  parameter int unsigned NUM_FILES   = 4,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned BUSY_CYCLES = 2
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [7:0]  file_num,
  input  logic        file_read,
  input  logic        file_write,
  input  logic        file_reset,
  input  logic [31:0] file_rd_ptr_offset,
  input  logic [31:0] file_write_data,
  output logic [31:0] file_read_data,
  output logic        file_active,
  output logic [31:0] rd_ptr,
  output logic [31:0] wr_ptr,
  input  logic        host_we,
  input  logic [7:0]  host_file,
  input  logic [31:0] host_data,
  output logic        host_ready,
  output logic        error,
  input  logic        error_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1;
  localparam int unsigned CW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_RELEASE} state_t;

  state_t        state_q, state_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW:0]   rd_ptr_q [NUM_FILES];
  logic [AW:0]   rd_ptr_d [NUM_FILES];
  logic [AW:0]   wr_ptr_q [NUM_FILES];
  logic [AW:0]   wr_ptr_d [NUM_FILES];
  logic [31:0]   rdata_q, rdata_d;
  logic          error_q, error_d;

  logic [31:0]   mem [NUM_FILES][DEPTH];
  logic          mem_we;
  logic [FW-1:0] mem_file;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  logic          any_cmd, accept, host_go;
  logic          cmd_valid, host_valid;
  logic [FW-1:0] cmd_fidx, host_fidx, wr_fidx;
  logic [AW-1:0] rd_idx;
  logic          wr_req, err_evt;
  logic [31:0]   wr_data;
  logic          unused_bits;

  assign any_cmd    = file_read | file_write | file_reset;
  assign cmd_valid  = 32'(file_num) < NUM_FILES;
  assign host_valid = 32'(host_file) < NUM_FILES;
  assign cmd_fidx   = file_num[FW-1:0];
  assign host_fidx  = host_file[FW-1:0];
  assign accept     = (state_q == IDLE) && armed_q && any_cmd;
  assign host_ready = (state_q == IDLE) && !any_cmd;
  assign host_go    = host_we && host_ready;
  // Offset is in bytes; only the word bits inside one file's range matter.
  assign rd_idx     = rd_ptr_q[cmd_fidx][AW-1:0] + file_rd_ptr_offset[AW+1:2];
  assign unused_bits = ^{file_rd_ptr_offset[31:AW+2], file_rd_ptr_offset[1:0]};

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    cnt_d     = cnt_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    rdata_d   = rdata_q;
    err_evt   = 1'b0;
    wr_req    = 1'b0;
    wr_fidx   = cmd_fidx;
    wr_data   = file_write_data;
    mem_we    = 1'b0;
    mem_file  = cmd_fidx;
    mem_addr  = '0;
    mem_wdata = file_write_data;

    case (state_q)
      IDLE: begin
        if (!any_cmd) armed_d = 1'b1;
        if (accept) begin
          state_d = ACTIVE;
          armed_d = 1'b0;
          cnt_d   = CW'(BUSY_CYCLES - 1);
        end
      end
      ACTIVE: begin
        if (cnt_q == '0) state_d = WAIT_RELEASE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      WAIT_RELEASE: begin
        if (!any_cmd) begin
          armed_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Command priority reset > write > read; host only when the engine is idle.
    if (accept) begin
      if (!cmd_valid) begin
        rdata_d = '0;
        err_evt = 1'b1;
      end else if (file_reset) begin
        rd_ptr_d[cmd_fidx] = '0;
      end else if (file_write) begin
        wr_req = 1'b1;
      end else begin
        if ({1'b0, rd_idx} < wr_ptr_q[cmd_fidx]) begin
          rdata_d = mem[cmd_fidx][rd_idx];
        end else begin
          rdata_d = '0;
          err_evt = 1'b1;
        end
        if (rd_ptr_q[cmd_fidx] != FULL)
          rd_ptr_d[cmd_fidx] = rd_ptr_q[cmd_fidx] + (AW + 1)'(1);
      end
    end else if (host_go) begin
      if (host_valid) begin
        wr_req  = 1'b1;
        wr_fidx = host_fidx;
        wr_data = host_data;
      end else begin
        err_evt = 1'b1;
      end
    end

    if (wr_req) begin
      if (wr_ptr_q[wr_fidx] == FULL) begin
        err_evt = 1'b1;
      end else begin
        mem_we            = 1'b1;
        mem_file          = wr_fidx;
        mem_addr          = wr_ptr_q[wr_fidx][AW-1:0];
        mem_wdata         = wr_data;
        wr_ptr_d[wr_fidx] = wr_ptr_q[wr_fidx] + (AW + 1)'(1);
      end
    end

    error_d = error_q;
    if (error_clr) error_d = 1'b0;
    if (err_evt)   error_d = 1'b1;
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= IDLE;
      armed_q <= 1'b1;
      cnt_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_FILES; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (mem_we) mem[mem_file][mem_addr] <= mem_wdata;
  end

  assign file_active    = (state_q == ACTIVE);
  assign file_read_data = rdata_q;
  assign error          = error_q;
  assign rd_ptr         = cmd_valid ? 32'(rd_ptr_q[cmd_fidx]) : '0;
  assign wr_ptr         = cmd_valid ? 32'(wr_ptr_q[cmd_fidx]) : '0;

endmodule
